corescore_uart_arbiter: RTL and testbench
=========================================

# corescore_uart_arbiter

Round-robin, line-granular arbiter that shares the single UART byte emitter among `num_req` byte-stream requesters (one per core). A requester holds the grant until it transfers an end-of-line byte, so text lines never interleave on the serial output. A timeout reclaims the grant from a requester that stalls mid-line. The arbiter sits between the per-core byte sources and the UART emitter's `i_data`/`i_valid`/`o_ready` handshake.

## Interface
- `num_req`, default 4: number of requesters; legal range 2..16.
- `eol_char`, default 8'h0A: byte value that ends a line and releases the grant.
- `timeout_cycles`, default 1024: idle-granted cycles before forced release; 0 disables the timeout.

Ports:
- `i_clk`  in  1  sole clock; all logic is on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_data`  in  8*num_req  requester bytes; requester k is `i_data[8k+7:8k]`.
- `i_valid`  in  num_req  per-requester byte valid.
- `o_ready`  out  num_req  per-requester accept; one-hot or zero.
- `o_data`  out  8  byte to the emitter.
- `o_valid`  out  1  byte valid to the emitter.
- `i_ready`  in  1  emitter ready (emitter's `o_ready`).
- `o_grant`  out  num_req  registered one-hot grant; zero when idle.

## Operation
- Transfer rules:
  - Upstream transfer k: `i_valid[k] & o_ready[k]`.
  - Downstream transfer: `o_valid & i_ready`.
  - Both occur in the same cycle.
- State machine: IDLE, GRANT.
- IDLE:
  - `o_valid`=0, `o_ready`=0.
  - If any `i_valid` is set, select the first set bit searching upward, with wrap, from `last+1`.
  - Register `o_grant` to that one-hot value, `gidx` to its index, and go to GRANT.
  - If no `i_valid` is set, stay in IDLE.
- GRANT, combinational pass-through:
  - `o_data` = `i_data` slice `gidx`.
  - `o_valid` = `i_valid[gidx]`.
  - `o_ready[gidx]` = `i_ready`; all other `o_ready` bits are 0.
- GRANT exit on end of line: a transfer whose byte equals `eol_char` moves to IDLE next cycle, with `last` <= `gidx` and `o_grant` <= 0.
- GRANT exit on timeout:
  - Timeout counter width is `$clog2(timeout_cycles+1)`.
  - The counter clears on entry to GRANT and on every transfer.
  - It increments each GRANT cycle where `i_valid[gidx]`=0.
  - It holds while `i_valid[gidx]`=1 and `i_ready`=0, so emitter backpressure never times out.
  - When the counter equals `timeout_cycles` (and `timeout_cycles` != 0), go to IDLE with `last` <= `gidx`. No byte is dropped, because no transfer is pending.
- Simultaneous events:
  - An EOL transfer in the same cycle the counter would expire is an EOL release; the counter clears.
  - Requests arriving during GRANT are only considered in IDLE. The current holder competes again only after all other pending requesters, per round-robin order.
- Data integrity: the arbiter never buffers bytes. The count of downstream bytes equals the count of upstream bytes, in order per requester.

## Timing
- Reset values:
  - State IDLE.
  - `o_grant`=0, `o_valid`=0, `o_ready`=0, `o_data`=0.
  - Timeout counter 0.
  - `last`=num_req-1, so requester 0 has first priority.
- Reset mid-line: forces IDLE within one cycle and abandons the line. There is no EOL insertion; the emitter finishes any byte it already accepted.
- Request-to-first-byte latency:
  - Request seen in IDLE at cycle c, `o_grant` valid at c+1.
  - `o_valid` can first be 1 at c+1.
  - Earliest transfer is at c+1.
- Release-to-next-grant: EOL transfer at cycle c, IDLE at c+1, next grant at c+2. This is exactly one dead cycle per line.
- Back-to-back bytes: sustained at the emitter's acceptance rate. The arbiter adds zero cycles per byte inside a line.
- Stability while `i_ready`=0: `o_data`/`o_valid` follow the granted requester. That requester must hold its byte stable while valid (standard valid/ready); the arbiter does not check this.

## Test plan
- Single line: requester 0 sends "HI\n" (0x48, 0x49, 0x0A) with an emitter model that accepts one byte per 10 cycles.
  - Emitter receives 48, 49, 0A.
  - `o_grant`=0001 from the cycle after the first valid until the cycle after the 0A transfer.
- Contention: requesters 0 and 1 each present "A\n" and "B\n" from the reset release.
  - Output is 41 0A 42 0A.
  - Never 41 42.
  - One IDLE cycle between the 0A transfer and `o_grant`=0010.
- Round-robin: requesters 0, 1 and 2 continuously send one-byte lines "\n".
  - Grant order is 0,1,2,0,1,2 over 6 lines.
  - Each requester receives exactly 2 `o_ready` pulses.
- Timeout: `timeout_cycles`=16; requester 1 sends "X" and then drops valid, while requester 2 is waiting.
  - Grant is released 16 cycles after the X transfer.
  - Requester 2 is granted 1 cycle later.
  - Requester 1's later "Y\n" completes after requester 2's line.
- Backpressure: `i_ready` is held 0 for 100 cycles while granted requester 0 holds 0x55.
  - No timeout occurs; `o_valid`=1 and `o_data`=55 throughout.
  - Exactly one transfer occurs when `i_ready` rises.
- Reset mid-line: assert `i_rst` for 1 cycle after requester 3 sends 2 of 5 bytes.
  - `o_grant`=0, `o_valid`=0 and `o_ready`=0 next cycle.
  - Requester 0 wins the next arbitration over a pending requester 3.

Source files
------------

// File: rtl/corescore_uart_arbiter.sv
// rtl/corescore_uart_arbiter.sv - line-granular round-robin arbiter in front of a UART byte emitter
//
// Shares one UART byte emitter among num_req byte-stream requesters. A requester
// keeps the grant until it transfers an eol_char byte, so text lines never
// interleave. A granted requester that stalls mid-line for timeout_cycles cycles
// loses the grant. Bytes are never buffered: data/valid/ready pass straight
// through between the granted requester and the emitter.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - synchronous active-high reset
//   i_data   - requester bytes, requester k on i_data[8k+7:8k]
//   i_valid  - per-requester byte valid
//   o_ready  - per-requester accept, one-hot or zero
//   o_data   - byte to the emitter
//   o_valid  - byte valid to the emitter
//   i_ready  - emitter ready
//   o_grant  - registered one-hot grant, zero when idle
module corescore_uart_arbiter #(
  parameter int         num_req        = 4,
  parameter logic [7:0] eol_char       = 8'h0A,
  parameter int         timeout_cycles = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*num_req-1:0] i_data,
  input  logic [num_req-1:0]   i_valid,
  output logic [num_req-1:0]   o_ready,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [num_req-1:0]   o_grant
);

  localparam int IW = $clog2(num_req);
  // A zero timeout still needs a 1-bit counter so the declaration stays legal.
  localparam int TW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e             state_q;
  logic [IW-1:0]      gidx_q;
  logic [IW-1:0]      last_q;
  logic [num_req-1:0] grant_q;
  logic [TW-1:0]      cnt_q;
  logic [TW-1:0]      cnt_d;

  logic [IW-1:0]      cand;
  logic [IW-1:0]      pick_idx;
  logic [num_req-1:0] pick_onehot;
  logic               pick_found;
  logic               cur_valid;
  logic               xfer;
  logic               eol_xfer;
  logic               timeout_hit;

  assign o_grant   = grant_q;
  assign cur_valid = i_valid[gidx_q];

  // Pass-through to the granted requester; everything is quiet in IDLE.
  always_comb begin
    o_data  = 8'h00;
    o_valid = 1'b0;
    o_ready = '0;
    if (state_q == S_GRANT) begin
      o_data          = i_data[{gidx_q, 3'b000} +: 8];
      o_valid         = cur_valid;
      o_ready[gidx_q] = i_ready;
    end
  end

  assign xfer     = o_valid & i_ready;
  assign eol_xfer = xfer & (o_data == eol_char);

  // Clear on transfer, count while the holder has nothing to send, hold under
  // emitter backpressure so a slow emitter never causes a release.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = '0;
    end else if (!cur_valid) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the cycle whose increment would reach timeout_cycles, so the
  // release lands after exactly timeout_cycles stalled cycles. A transfer
  // implies cur_valid, so an EOL in the same cycle always wins.
  assign timeout_hit = (timeout_cycles != 0) && !cur_valid && (cnt_q == TO_LAST);

  // Round-robin search upward from last+1 with wrap; the previous holder is
  // visited last.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = last_q;
    cand        = last_q;
    pick_onehot = '0;
    for (int i = 1; i <= num_req; i++) begin
      cand = IW'((int'(last_q) + i) % num_req);
      if (!pick_found && i_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot[pick_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(num_req - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (pick_found) begin
            state_q <= S_GRANT;
            gidx_q  <= pick_idx;
            grant_q <= pick_onehot;
          end
        end
        S_GRANT: begin
          if (eol_xfer || timeout_hit) begin
            state_q <= S_IDLE;
            last_q  <= gidx_q;
            grant_q <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corescore_uart_arbiter.sv
// tb/tb_corescore_uart_arbiter.sv - directed self-checking bench for corescore_uart_arbiter
module tb_corescore_uart_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_data;
  logic [3:0]  i_valid;
  logic [3:0]  o_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_grant;

  always #5 i_clk = ~i_clk;

  corescore_uart_arbiter #(
    .num_req(4),
    .eol_char(8'h0A),
    .timeout_cycles(16)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_grant(o_grant)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;   // 0: emitter always ready, 1: one byte per 10 cycles, 2: stalled

  logic [7:0] srcq [4][$];
  logic [7:0] dq [$];
  logic [3:0] dg [$];
  int         dc [$];
  logic [3:0] gh [0:2047];
  logic [3:0] rh [0:2047];
  logic       vh [0:2047];
  logic [7:0] dh [0:2047];
  int         rdy_cnt [4];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dq_at(int i);
    return (i < dq.size()) ? {24'h0, dq[i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] dg_at(int i);
    return (i < dg.size()) ? {28'h0, dg[i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] dc_at(int i);
    return (i < dc.size()) ? dc[i] : 32'hDEAD;
  endfunction

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      if (srcq[k].size() > 0) begin
        i_valid[k]       = 1'b1;
        i_data[8*k +: 8] = srcq[k][0];
      end else begin
        i_valid[k]       = 1'b0;
        i_data[8*k +: 8] = 8'h00;
      end
    end
    case (mode)
      0:       i_ready = 1'b1;
      1:       i_ready = (cyc % 10 == 9);
      default: i_ready = 1'b0;
    endcase
  endtask

  // Observe cycle cyc at the falling edge, then advance sources past the edge.
  task automatic tick();
    logic [3:0] pop;
    @(negedge i_clk);
    if (cyc < 2048) begin
      gh[cyc] = o_grant;
      rh[cyc] = o_ready;
      vh[cyc] = o_valid;
      dh[cyc] = o_data;
    end
    pop = '0;
    for (int k = 0; k < 4; k++) begin
      if (o_ready[k]) rdy_cnt[k]++;
      if (i_valid[k] && o_ready[k]) pop[k] = 1'b1;
    end
    if (o_valid && i_ready) begin
      dq.push_back(o_data);
      dg.push_back(o_grant);
      dc.push_back(cyc);
    end
    @(posedge i_clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (pop[k]) void'(srcq[k].pop_front());
    end
    refresh();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut();
    i_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      srcq[k].delete();
      rdy_cnt[k] = 0;
    end
    mode = 0;
    refresh();
    tick_n(2);
    i_rst = 1'b0;
    dq.delete();
    dg.delete();
    dc.delete();
    for (int k = 0; k < 4; k++) rdy_cnt[k] = 0;
    refresh();
  endtask

  initial begin
    int r;
    int t [3];
    int j;
    int bad;

    // Reset state, with every requester shouting during reset.
    i_rst   = 1'b1;
    i_valid = 4'hF;
    i_data  = 32'hA5A5_A5A5;
    i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    expect_eq("rst_grant", {28'h0, o_grant}, 32'h0);
    expect_eq("rst_valid", {31'h0, o_valid}, 32'h0);
    expect_eq("rst_ready", {28'h0, o_ready}, 32'h0);
    expect_eq("rst_data",  {24'h0, o_data},  32'h0);

    // Single line "HI\n" from requester 0, emitter takes one byte per 10 cycles.
    reset_dut();
    r = cyc;
    mode = 1;
    srcq[0].push_back(8'h48);
    srcq[0].push_back(8'h49);
    srcq[0].push_back(8'h0A);
    refresh();
    j = 0;
    for (int n = r + 1; j < 3; n++) begin
      if (n % 10 == 9) begin
        t[j] = n;
        j++;
      end
    end
    tick_n(35);
    expect_eq("t1_b0", dq_at(0), 32'h48);
    expect_eq("t1_b1", dq_at(1), 32'h49);
    expect_eq("t1_b2", dq_at(2), 32'h0A);
    expect_eq("t1_cnt", dq.size(), 3);
    expect_eq("t1_t2", dc_at(2), t[2]);
    expect_eq("t1_g_req", {28'h0, gh[r]}, 32'h0);
    bad = 0;
    for (int n = r + 1; n <= t[2]; n++) if (gh[n] !== 4'b0001) bad++;
    expect_eq("t1_g_hold", bad, 0);
    expect_eq("t1_g_rel", {28'h0, gh[t[2] + 1]}, 32'h0);

    // Contention: "A\n" and "B\n" from requesters 0 and 1 at once.
    reset_dut();
    r = cyc;
    srcq[0].push_back(8'h41);
    srcq[0].push_back(8'h0A);
    srcq[1].push_back(8'h42);
    srcq[1].push_back(8'h0A);
    refresh();
    tick_n(10);
    expect_eq("t2_b0", dq_at(0), 32'h41);
    expect_eq("t2_b1", dq_at(1), 32'h0A);
    expect_eq("t2_b2", dq_at(2), 32'h42);
    expect_eq("t2_b3", dq_at(3), 32'h0A);
    expect_eq("t2_eol_cyc", dc_at(1), r + 2);
    expect_eq("t2_dead", {28'h0, gh[r + 3]}, 32'h0);
    expect_eq("t2_g1", {28'h0, gh[r + 4]}, 32'h2);
    expect_eq("t2_b2_cyc", dc_at(2), r + 4);

    // Round-robin among requesters 0..2 sending one-byte lines.
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      srcq[k].push_back(8'h0A);
      srcq[k].push_back(8'h0A);
    end
    refresh();
    tick_n(16);
    for (int i = 0; i < 6; i++) expect_eq($sformatf("t3_order%0d", i), dg_at(i), 32'h1 << (i % 3));
    expect_eq("t3_rdy0", rdy_cnt[0], 2);
    expect_eq("t3_rdy1", rdy_cnt[1], 2);
    expect_eq("t3_rdy2", rdy_cnt[2], 2);
    expect_eq("t3_rdy3", rdy_cnt[3], 0);

    // Timeout: requester 1 sends "X" and stalls while requester 2 waits.
    reset_dut();
    r = cyc;
    srcq[1].push_back(8'h58);
    srcq[2].push_back(8'h5A);
    srcq[2].push_back(8'h0A);
    refresh();
    tick_n(18);
    srcq[1].push_back(8'h59);
    srcq[1].push_back(8'h0A);
    refresh();
    tick_n(12);
    expect_eq("t4_x_cyc", dc_at(0), r + 1);
    expect_eq("t4_hold", {28'h0, gh[r + 17]}, 32'h2);
    expect_eq("t4_rel", {28'h0, gh[r + 18]}, 32'h0);
    expect_eq("t4_g2", {28'h0, gh[r + 19]}, 32'h4);
    expect_eq("t4_b0", dq_at(0), 32'h58);
    expect_eq("t4_b1", dq_at(1), 32'h5A);
    expect_eq("t4_b2", dq_at(2), 32'h0A);
    expect_eq("t4_b3", dq_at(3), 32'h59);
    expect_eq("t4_b4", dq_at(4), 32'h0A);
    expect_eq("t4_y_owner", dg_at(3), 32'h2);

    // Backpressure: emitter stalled 100 cycles while requester 0 holds 0x55.
    reset_dut();
    r = cyc;
    mode = 2;
    srcq[0].push_back(8'h55);
    srcq[0].push_back(8'h0A);
    refresh();
    tick_n(101);
    bad = 0;
    for (int n = r + 1; n <= r + 100; n++) begin
      if (gh[n] !== 4'b0001 || vh[n] !== 1'b1 || dh[n] !== 8'h55) bad++;
    end
    expect_eq("t5_stall_ok", bad, 0);
    expect_eq("t5_no_xfer", dq.size(), 0);
    mode = 0;
    refresh();
    tick_n(5);
    expect_eq("t5_cnt", dq.size(), 2);
    expect_eq("t5_b0", dq_at(0), 32'h55);
    expect_eq("t5_b0_cyc", dc_at(0), r + 101);
    expect_eq("t5_b1", dq_at(1), 32'h0A);

    // Reset mid-line: requester 3 sends 2 of 5 bytes, then a 1-cycle reset.
    reset_dut();
    r = cyc;
    srcq[3].push_back(8'h31);
    srcq[3].push_back(8'h32);
    srcq[3].push_back(8'h33);
    srcq[3].push_back(8'h34);
    srcq[3].push_back(8'h0A);
    refresh();
    tick_n(3);
    expect_eq("t6_sent", dq.size(), 2);
    i_rst = 1'b1;
    mode = 2;
    srcq[0].push_back(8'h41);
    srcq[0].push_back(8'h0A);
    refresh();
    tick();
    i_rst = 1'b0;
    mode = 0;
    refresh();
    tick_n(4);
    expect_eq("t6_grant0", {28'h0, gh[r + 4]}, 32'h0);
    expect_eq("t6_valid0", {31'h0, vh[r + 4]}, 32'h0);
    expect_eq("t6_ready0", {28'h0, rh[r + 4]}, 32'h0);
    expect_eq("t6_winner", {28'h0, gh[r + 5]}, 32'h1);
    expect_eq("t6_first", dq_at(2), 32'h41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
